pmu_clk_seq: RTL and testbench
==============================

// Module: pmu_clk_seq
// PURPOSE
// Power/clock sequencer directly upstream of the CRGU, clocked by the always-on clk_32k.
// Produces the CRGU clock-enable inputs (timer/data/efuse/afe/slot) and the shut_rstn and
// pmu_fifo_rstn reset requests. Does this with timed, ordered power-up / power-down sequences
// driven by rg_top_start, a shutdown request and a FIFO flush request.
// PARAMETERS
// STEP_DLY    4   clk_32k cycles between successive enable steps (1..255)
// AFE_SETTLE  16  cycles afe_clk_en is held before slot_clk_en rises (1..255)
// EFUSE_TMO   64  max cycles waiting for efuse_done before forcing on (1..255)
// RST_PULSE   2   shut_rstn low width, cycles (1..255)
// FIFO_PULSE  2   pmu_fifo_rstn low width, cycles (1..255)
// PORTS
// clk_32k         in   1  always-on 32 kHz clock
// rst_32k_alon_n  in   1  synchronous active-low reset
// rg_top_start    in   1  level; 1 = run measurement chain, 0 = stop
// rg_shut_req     in   1  single-cycle pulse: software shutdown reset request
// rg_fifo_flush   in   1  single-cycle pulse: FIFO reset request
// efuse_done      in   1  level from efuse controller: load complete
// timer_clk_en    out  1  to CRGU
// efuse_clk_en    out  1  to CRGU
// data_clk_en     out  1  to CRGU
// afe_clk_en      out  1  to CRGU
// slot_clk_en     out  1  to CRGU
// shut_rstn       out  1  to CRGU, active-low shutdown reset
// pmu_fifo_rstn   out  1  to CRGU, active-low FIFO reset
// pmu_busy        out  1  1 in any state except IDLE and RUN
// efuse_err       out  1  sticky: efuse timeout occurred; cleared only by reset
// pmu_state       out  3  current FSM state encoding
// BEHAVIOUR
// - Reset (sync, rst_32k_alon_n=0 at posedge) values:
//   - all *_clk_en=0, shut_rstn=1, pmu_fifo_rstn=1, efuse_err=0
//   - state=EFUSE, cnt=0
// - All outputs registered; one 8-bit down/up counter cnt shared by FSM; separate 8-bit fifo counter.
// - States:
//   - EFUSE=0: efuse_clk_en=1; efuse_done=1 or cnt==EFUSE_TMO-1 -> IDLE. Timeout (done still 0) sets efuse_err.
//   - IDLE=1: efuse_clk_en=0, timer_clk_en=1 (stays 1 in every later state except SHUT).
//     rg_top_start=1 -> DATA.
//   - DATA=2: data_clk_en=1; after STEP_DLY cycles -> AFE.
//   - AFE=3: afe_clk_en=1; after AFE_SETTLE cycles -> RUN.
//   - RUN=4: slot_clk_en=1; rg_top_start=0 -> STOP.
//   - STOP=5: slot_clk_en=0 on entry; afe_clk_en=0 at cnt==STEP_DLY;
//     data_clk_en=0 and -> IDLE at cnt==2*STEP_DLY.
//   - SHUT=6: all enables 0; shut_rstn=0 for RST_PULSE cycles, then 1 and -> EFUSE (efuse reload).
// - "after N cycles": enable rises on the state-entry edge; transition on the Nth following posedge.
// - rg_top_start=0 while in DATA or AFE -> STOP immediately.
//   STOP disables only enables currently set, using the same timing.
// - rg_top_start=1 during STOP is ignored until IDLE is reached; then IDLE -> DATA next cycle.
// - rg_shut_req priority: overrides any state/transition in the same cycle -> SHUT.
//   A shut_req while in SHUT restarts the RST_PULSE count.
// - rg_fifo_flush: pmu_fifo_rstn=0 for FIFO_PULSE cycles starting next edge.
//   A flush while already low is ignored (no extension). Independent of FSM state.
//   Also forced low throughout SHUT.
// - rg_top_start in EFUSE/SHUT: no effect until IDLE.
// - Enables never toggle twice in one cycle; no glitch paths (all from flops).
// TESTING
// - Reset release, efuse_done=1 at cycle 3 -> efuse_clk_en 1 for cycles 0..3; IDLE at cycle 4; timer_clk_en=1.
// - efuse_done held 0 -> IDLE after 64 cycles, efuse_err=1 and stays 1 through shut/restart.
// - rg_top_start=1 in IDLE -> data_clk_en +1 cycle, afe_clk_en +5, slot_clk_en +21 (defaults); pmu_busy 1 until RUN.
// - rg_top_start=0 in RUN -> slot off +1, afe off +5, data off +9, IDLE; restart during STOP waits for IDLE.
// - rg_shut_req in AFE, simultaneous with rg_top_start=0 -> SHUT wins; enables 0, shut_rstn low 2 cycles, then EFUSE.
// - rg_fifo_flush pulse -> pmu_fifo_rstn low exactly 2 cycles; second flush 1 cycle later does not extend it.

Source files
------------

// File: rtl/pmu_clk_seq.sv
// pmu_clk_seq: always-on power/clock sequencer feeding the CRGU.
// Orders clock-enable bring-up (efuse -> timer -> data -> afe -> slot) and tear-down,
// and generates the shutdown and FIFO reset pulses. Every output comes from a flop.
module pmu_clk_seq #(
    parameter int STEP_DLY   = 4,
    parameter int AFE_SETTLE = 16,
    parameter int EFUSE_TMO  = 64,
    parameter int RST_PULSE  = 2,
    parameter int FIFO_PULSE = 2
) (
    input  logic       clk_32k,
    input  logic       rst_32k_alon_n,
    input  logic       rg_top_start,
    input  logic       rg_shut_req,
    input  logic       rg_fifo_flush,
    input  logic       efuse_done,
    output logic       timer_clk_en,
    output logic       efuse_clk_en,
    output logic       data_clk_en,
    output logic       afe_clk_en,
    output logic       slot_clk_en,
    output logic       shut_rstn,
    output logic       pmu_fifo_rstn,
    output logic       pmu_busy,
    output logic       efuse_err,
    output logic [2:0] pmu_state
);

    typedef enum logic [2:0] {
        ST_EFUSE = 3'd0,
        ST_IDLE  = 3'd1,
        ST_DATA  = 3'd2,
        ST_AFE   = 3'd3,
        ST_RUN   = 3'd4,
        ST_STOP  = 3'd5,
        ST_SHUT  = 3'd6
    } state_t;

    // Terminal counts: a wait of N cycles ends when the counter holds N-1.
    localparam logic [7:0] STEP_LAST  = 8'(STEP_DLY - 1);
    localparam logic [7:0] SETTLE_LAST = 8'(AFE_SETTLE - 1);
    localparam logic [7:0] TMO_LAST   = 8'(EFUSE_TMO - 1);
    localparam logic [7:0] RST_LAST   = 8'(RST_PULSE - 1);
    localparam logic [7:0] FIFO_LAST  = 8'(FIFO_PULSE - 1);

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    // STOP is two STEP_DLY halves (afe off, then data off); this flag marks the second half
    // so the shared 8-bit counter never has to reach 2*STEP_DLY.
    logic       stop_ph_q, stop_ph_d;
    logic       efuse_err_q, efuse_err_d;
    logic       fifo_act_q, fifo_act_d;
    logic [7:0] fifo_cnt_q, fifo_cnt_d;

    logic timer_en_q, timer_en_d;
    logic efuse_en_q, efuse_en_d;
    logic data_en_q, data_en_d;
    logic afe_en_q, afe_en_d;
    logic slot_en_q, slot_en_d;
    logic shut_rstn_q, shut_rstn_d;
    logic fifo_rstn_q, fifo_rstn_d;
    logic busy_q, busy_d;

    // State register plus all registered outputs, synchronous active-low reset.
    always_ff @(posedge clk_32k) begin
        if (!rst_32k_alon_n) begin
            state_q     <= ST_EFUSE;
            cnt_q       <= 8'd0;
            stop_ph_q   <= 1'b0;
            efuse_err_q <= 1'b0;
            fifo_act_q  <= 1'b0;
            fifo_cnt_q  <= 8'd0;
            timer_en_q  <= 1'b0;
            efuse_en_q  <= 1'b0;
            data_en_q   <= 1'b0;
            afe_en_q    <= 1'b0;
            slot_en_q   <= 1'b0;
            shut_rstn_q <= 1'b1;
            fifo_rstn_q <= 1'b1;
            busy_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            stop_ph_q   <= stop_ph_d;
            efuse_err_q <= efuse_err_d;
            fifo_act_q  <= fifo_act_d;
            fifo_cnt_q  <= fifo_cnt_d;
            timer_en_q  <= timer_en_d;
            efuse_en_q  <= efuse_en_d;
            data_en_q   <= data_en_d;
            afe_en_q    <= afe_en_d;
            slot_en_q   <= slot_en_d;
            shut_rstn_q <= shut_rstn_d;
            fifo_rstn_q <= fifo_rstn_d;
            busy_q      <= busy_d;
        end
    end

    // Next-state and counter logic; a shutdown request overrides everything else.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        stop_ph_d   = 1'b0;
        efuse_err_d = efuse_err_q;
        if (rg_shut_req) begin
            state_d = ST_SHUT;
            cnt_d   = 8'd0;
        end else begin
            case (state_q)
                ST_EFUSE: begin
                    if (efuse_done) begin
                        state_d = ST_IDLE;
                        cnt_d   = 8'd0;
                    end else if (cnt_q == TMO_LAST) begin
                        state_d     = ST_IDLE;
                        cnt_d       = 8'd0;
                        efuse_err_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
                ST_IDLE: begin
                    cnt_d = 8'd0;
                    if (rg_top_start) state_d = ST_DATA;
                end
                ST_DATA: begin
                    if (!rg_top_start) begin
                        state_d = ST_STOP;
                        cnt_d   = 8'd0;
                    end else if (cnt_q == STEP_LAST) begin
                        state_d = ST_AFE;
                        cnt_d   = 8'd0;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
                ST_AFE: begin
                    if (!rg_top_start) begin
                        state_d = ST_STOP;
                        cnt_d   = 8'd0;
                    end else if (cnt_q == SETTLE_LAST) begin
                        state_d = ST_RUN;
                        cnt_d   = 8'd0;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
                ST_RUN: begin
                    cnt_d = 8'd0;
                    if (!rg_top_start) state_d = ST_STOP;
                end
                ST_STOP: begin
                    if (cnt_q == STEP_LAST) begin
                        cnt_d = 8'd0;
                        if (stop_ph_q) state_d = ST_IDLE;
                        else           stop_ph_d = 1'b1;
                    end else begin
                        cnt_d     = cnt_q + 8'd1;
                        stop_ph_d = stop_ph_q;
                    end
                end
                ST_SHUT: begin
                    if (cnt_q == RST_LAST) begin
                        state_d = ST_EFUSE;
                        cnt_d   = 8'd0;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
                default: begin
                    state_d = ST_EFUSE;
                    cnt_d   = 8'd0;
                end
            endcase
        end
    end

    // Output next values derived from the upcoming state, so enables change on state-entry edges.
    always_comb begin
        efuse_en_d  = (state_d == ST_EFUSE);
        timer_en_d  = (state_d != ST_EFUSE) && (state_d != ST_SHUT);
        slot_en_d   = (state_d == ST_RUN);
        shut_rstn_d = (state_d != ST_SHUT);
        busy_d      = (state_d != ST_IDLE) && (state_d != ST_RUN);
        data_en_d   = 1'b0;
        afe_en_d    = 1'b0;
        case (state_d)
            ST_DATA: data_en_d = 1'b1;
            ST_AFE, ST_RUN: begin
                data_en_d = 1'b1;
                afe_en_d  = 1'b1;
            end
            ST_STOP: begin
                // Only enables that were on at STOP entry are held, then dropped on schedule.
                data_en_d = data_en_q;
                afe_en_d  = afe_en_q && !((state_q == ST_STOP) && (cnt_q == STEP_LAST));
            end
            default: ;
        endcase
    end

    // FIFO reset pulse: fixed width, a request while the reset is already low is dropped.
    always_comb begin
        fifo_act_d = fifo_act_q;
        fifo_cnt_d = fifo_cnt_q;
        if (fifo_act_q) begin
            if (fifo_cnt_q == FIFO_LAST) fifo_act_d = 1'b0;
            else                         fifo_cnt_d = fifo_cnt_q + 8'd1;
        end else if (rg_fifo_flush && fifo_rstn_q) begin
            fifo_act_d = 1'b1;
            fifo_cnt_d = 8'd0;
        end
        fifo_rstn_d = !(fifo_act_d || (state_d == ST_SHUT));
    end

    assign timer_clk_en  = timer_en_q;
    assign efuse_clk_en  = efuse_en_q;
    assign data_clk_en   = data_en_q;
    assign afe_clk_en    = afe_en_q;
    assign slot_clk_en   = slot_en_q;
    assign shut_rstn     = shut_rstn_q;
    assign pmu_fifo_rstn = fifo_rstn_q;
    assign pmu_busy      = busy_q;
    assign efuse_err     = efuse_err_q;
    assign pmu_state     = state_q;

endmodule

// File: tb/tb_pmu_clk_seq.sv
// Bench for pmu_clk_seq: directed sequences from the bring-up/tear-down scenarios, then
// random traffic, all compared cycle by cycle against a behavioural model.
module tb_pmu_clk_seq;

    localparam int STEP_DLY   = 4;
    localparam int AFE_SETTLE = 16;
    localparam int EFUSE_TMO  = 64;
    localparam int RST_PULSE  = 2;
    localparam int FIFO_PULSE = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, start, shut, flush, done;
    logic       timer_en, efuse_en, data_en, afe_en, slot_en;
    logic       shut_rstn, fifo_rstn, busy, err;
    logic [2:0] state;

    pmu_clk_seq #(
        .STEP_DLY(STEP_DLY), .AFE_SETTLE(AFE_SETTLE), .EFUSE_TMO(EFUSE_TMO),
        .RST_PULSE(RST_PULSE), .FIFO_PULSE(FIFO_PULSE)
    ) dut (
        .clk_32k(clk), .rst_32k_alon_n(rst_n), .rg_top_start(start),
        .rg_shut_req(shut), .rg_fifo_flush(flush), .efuse_done(done),
        .timer_clk_en(timer_en), .efuse_clk_en(efuse_en), .data_clk_en(data_en),
        .afe_clk_en(afe_en), .slot_clk_en(slot_en), .shut_rstn(shut_rstn),
        .pmu_fifo_rstn(fifo_rstn), .pmu_busy(busy), .efuse_err(err), .pmu_state(state)
    );

    int n_assert = 0;
    int n_fail   = 0;

    // Model: state number, cycles since entering it, whether afe was running when STOP began,
    // sticky error, remaining FIFO-reset low cycles, and "just reset" (outputs at reset values).
    int m_st = 0;
    int m_e = 0;
    bit m_afe_entry = 0;
    bit m_err = 0;
    int m_rem = 0;
    bit m_rstview = 1;

    task automatic model_edge();
        bit fifo_low;
        if (!rst_n) begin
            m_st = 0; m_e = 0; m_err = 0; m_rem = 0; m_rstview = 1; m_afe_entry = 0;
            return;
        end
        fifo_low = (m_rem > 0) || (m_st == 6);
        if (m_rem > 0) m_rem--;
        else if (flush && !fifo_low) m_rem = FIFO_PULSE;
        m_rstview = 0;
        if (shut) begin
            m_st = 6; m_e = 0;
        end else begin
            case (m_st)
                0: if (done) begin m_st = 1; m_e = 0; end
                   else if (m_e == EFUSE_TMO - 1) begin m_st = 1; m_e = 0; m_err = 1; end
                   else m_e++;
                1: if (start) begin m_st = 2; m_e = 0; end
                2: if (!start) begin m_st = 5; m_e = 0; m_afe_entry = 0; end
                   else if (m_e == STEP_DLY - 1) begin m_st = 3; m_e = 0; end
                   else m_e++;
                3: if (!start) begin m_st = 5; m_e = 0; m_afe_entry = 1; end
                   else if (m_e == AFE_SETTLE - 1) begin m_st = 4; m_e = 0; end
                   else m_e++;
                4: if (!start) begin m_st = 5; m_e = 0; m_afe_entry = 1; end
                5: if (m_e == 2 * STEP_DLY - 1) begin m_st = 1; m_e = 0; end
                   else m_e++;
                default: if (m_e == RST_PULSE - 1) begin m_st = 0; m_e = 0; end
                   else m_e++;
            endcase
        end
    endtask

    function automatic logic [11:0] model_outs();
        logic x_timer, x_efuse, x_data, x_afe, x_slot, x_shut, x_fifo, x_busy;
        x_efuse = (m_st == 0) && !m_rstview;
        x_timer = (m_st != 0) && (m_st != 6);
        x_data  = (m_st >= 2) && (m_st <= 5);
        x_afe   = (m_st == 3) || (m_st == 4) || ((m_st == 5) && m_afe_entry && (m_e < STEP_DLY));
        x_slot  = (m_st == 4);
        x_shut  = (m_st != 6);
        x_fifo  = !((m_rem > 0) || (m_st == 6));
        x_busy  = (m_st != 1) && (m_st != 4);
        return {x_timer, x_efuse, x_data, x_afe, x_slot, x_shut, x_fifo, x_busy, m_err, 3'(m_st)};
    endfunction

    task automatic tick();
        logic [11:0] obs, exp;
        @(posedge clk);
        model_edge();
        #1;
        obs = {timer_en, efuse_en, data_en, afe_en, slot_en, shut_rstn, fifo_rstn, busy, err, state};
        exp = model_outs();
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL outs t=%0t observed=%b expected=%b", $time, obs, exp);
        end
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s t=%0t observed=%0d expected=%0d", tag, $time, obs, exp);
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; shut = 1'b0; flush = 1'b0; done = 1'b0;
        ticks(2);
        chk("rst_efuse", 8'(efuse_en), 8'd0);
        chk("rst_shutn", 8'(shut_rstn), 8'd1);
        chk("rst_state", 8'(state), 8'd0);
        rst_n = 1'b1;

        // efuse completes at cycle 3 -> IDLE at cycle 4
        ticks(4);
        chk("efuse_c3", 8'(efuse_en), 8'd1);
        done = 1'b1;
        tick();
        chk("idle_c4", 8'(state), 8'd1);
        chk("timer_on", 8'(timer_en), 8'd1);
        chk("efuse_off", 8'(efuse_en), 8'd0);

        // bring-up latencies: data +1, afe +5, slot +21
        start = 1'b1;
        tick();
        chk("data_p1", 8'(data_en), 8'd1);
        ticks(3);
        chk("afe_p4", 8'(afe_en), 8'd0);
        tick();
        chk("afe_p5", 8'(afe_en), 8'd1);
        ticks(15);
        chk("slot_p20", 8'(slot_en), 8'd0);
        chk("busy_p20", 8'(busy), 8'd1);
        tick();
        chk("slot_p21", 8'(slot_en), 8'd1);
        chk("busy_run", 8'(busy), 8'd0);
        ticks(3);

        // tear-down: slot +1, afe +5, data +9; restart during STOP waits for IDLE
        start = 1'b0;
        tick();
        chk("slot_off_p1", 8'(slot_en), 8'd0);
        ticks(3);
        chk("afe_p4_on", 8'(afe_en), 8'd1);
        tick();
        chk("afe_off_p5", 8'(afe_en), 8'd0);
        start = 1'b1;
        ticks(3);
        chk("data_p8_on", 8'(data_en), 8'd1);
        tick();
        chk("data_off_p9", 8'(data_en), 8'd0);
        chk("stop_idle", 8'(state), 8'd1);
        tick();
        chk("restart", 8'(state), 8'd2);

        // shut request in AFE together with start=0: SHUT wins
        ticks(6);
        chk("in_afe", 8'(state), 8'd3);
        start = 1'b0; shut = 1'b1;
        tick();
        shut = 1'b0;
        chk("shut_win", 8'(state), 8'd6);
        chk("shut_ens", 8'({timer_en, efuse_en, data_en, afe_en, slot_en}), 8'd0);
        chk("shutn_c1", 8'(shut_rstn), 8'd0);
        tick();
        chk("shutn_c2", 8'(shut_rstn), 8'd0);
        tick();
        chk("shutn_rel", 8'(shut_rstn), 8'd1);
        chk("reload", 8'(state), 8'd0);
        tick();

        // flush pulse: low exactly 2 cycles, back-to-back request ignored
        flush = 1'b1;
        tick();
        chk("fifo_c1", 8'(fifo_rstn), 8'd0);
        tick();
        flush = 1'b0;
        chk("fifo_c2", 8'(fifo_rstn), 8'd0);
        tick();
        chk("fifo_rel", 8'(fifo_rstn), 8'd1);

        // efuse timeout, then sticky error across shut/restart
        done = 1'b0; shut = 1'b1;
        tick();
        shut = 1'b0;
        ticks(2);
        chk("tmo_entry", 8'(state), 8'd0);
        ticks(63);
        chk("tmo_wait", 8'(state), 8'd0);
        chk("tmo_noerr", 8'(err), 8'd0);
        tick();
        chk("tmo_idle", 8'(state), 8'd1);
        chk("tmo_err", 8'(err), 8'd1);
        done = 1'b1; shut = 1'b1;
        tick();
        shut = 1'b0;
        ticks(4);
        chk("err_sticky", 8'(err), 8'd1);

        // random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            rst_n = ($urandom_range(0, 699) != 0);
            if ($urandom_range(0, 39) == 0) start = ~start;
            shut  = ($urandom_range(0, 149) == 0);
            flush = ($urandom_range(0, 24) == 0);
            done  = ($urandom_range(0, 15) == 0);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
